// File: rtl/clefia_pkg.sv
// clefia_pkg: shared encodings for the CLEFIA round controller.
// Holds FSM state encoding, round counts per key length, key_len codes,
// sel1 feedback tap codes and a helper that maps key_len to the last round index.
package clefia_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_OUT   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [4:0] ROUNDS_128 = 5'd18;
  localparam logic [4:0] ROUNDS_192 = 5'd22;
  localparam logic [4:0] ROUNDS_256 = 5'd26;

  localparam logic [1:0] KEY_128 = 2'b00;
  localparam logic [1:0] KEY_192 = 2'b01;
  localparam logic [1:0] KEY_256 = 2'b10;

  // Feedback tap select for the word register chain.
  localparam logic [1:0] SEL1_R7 = 2'b00;
  localparam logic [1:0] SEL1_R3 = 2'b01;
  localparam logic [1:0] SEL1_R1 = 2'b10;

  // Index of the final round (r-1); the reserved code 11 behaves like 128-bit.
  function automatic logic [4:0] last_round(input logic [1:0] kl);
    case (kl)
      KEY_192: last_round = ROUNDS_192 - 5'd1;
      KEY_256: last_round = ROUNDS_256 - 5'd1;
      default: last_round = ROUNDS_128 - 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/clefia_round_cnt.sv
// clefia_round_cnt: 2-bit phase counter (ph) and 5-bit round counter (i).
// Latency: next-count values are combinational; ph/i register on the rising edge.
// Backpressure: none; counts only when enabled, clear has priority over enable.
// Ports: clr/ph_en/i_en control, last_i = final round index;
//        ph_nxt/i_nxt = values after this edge, ph_last = (ph==3), tc = final phase of final round.
module clefia_round_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       ph_en,
  input  logic       i_en,
  input  logic [4:0] last_i,
  output logic [1:0] ph_nxt,
  output logic [4:0] i_nxt,
  output logic       ph_last,
  output logic       tc
);

  logic [1:0] ph;
  logic [4:0] i;

  always_comb begin
    ph_nxt = ph;
    i_nxt  = i;
    if (clr) begin
      ph_nxt = 2'd0;
      i_nxt  = 5'd0;
    end else if (ph_en) begin
      ph_nxt = ph + 2'd1;
      // Round index advances only when the phase wraps 3->0.
      if (i_en && (ph == 2'd3)) begin
        i_nxt = i + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= 2'd0;
      i  <= 5'd0;
    end else begin
      ph <= ph_nxt;
      i  <= i_nxt;
    end
  end

  assign ph_last = (ph == 2'd3);
  assign tc      = ph_last && (i == last_i);

endmodule

// File: rtl/clefia_round_ctrl.sv
// clefia_round_ctrl: sequences one CLEFIA block: LOAD(4) -> ROUND(4r) -> OUT(4) -> DONE(1).
// Latency: done in the 4+4r+5th cycle counting the start-acceptance cycle as the first; all outputs registered.
// Backpressure: start accepted only while ready (IDLE); abort returns to IDLE on the next edge.
// Ports: start/key_len/dec/abort in; ready, in_ready, sel1, sel2, f_sel, rk_addr,
//        wk_en/wk_sel, round, out_valid, done out.
module clefia_round_ctrl
  import clefia_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] key_len,
  input  logic       dec,
  input  logic       abort,
  output logic       ready,
  output logic       in_ready,
  output logic [1:0] sel1,
  output logic       sel2,
  output logic       f_sel,
  output logic [5:0] rk_addr,
  output logic       wk_en,
  output logic [1:0] wk_sel,
  output logic [4:0] round,
  output logic       out_valid,
  output logic       done
);

  state_t     state, state_nxt;
  logic       dec_q, dec_n;
  logic [4:0] last_q, last_n;
  logic       accept;
  logic       cnt_clr, ph_en, i_en;
  logic [1:0] ph_nxt;
  logic [4:0] i_nxt;
  logic       ph_last, tc;

  clefia_round_cnt u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .ph_en   (ph_en),
    .i_en    (i_en),
    .last_i  (last_q),
    .ph_nxt  (ph_nxt),
    .i_nxt   (i_nxt),
    .ph_last (ph_last),
    .tc      (tc)
  );

  // Next-state and counter control.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    ph_en     = 1'b0;
    i_en      = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ph_en = 1'b1;
        if (ph_last) state_nxt = ST_ROUND;
      end
      ST_ROUND: begin
        ph_en = 1'b1;
        i_en  = 1'b1;
        if (tc) begin
          // Clear so i does not step past the last round into OUT.
          state_nxt = ST_OUT;
          cnt_clr   = 1'b1;
        end
      end
      ST_OUT: begin
        ph_en = 1'b1;
        if (ph_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        cnt_clr   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        cnt_clr   = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
    if (abort) begin
      state_nxt = ST_IDLE;
      cnt_clr   = 1'b1;
      accept    = 1'b0;
    end
  end

  // Mode seen by the cycle being decoded: fresh inputs on the accepting edge, latched copy afterwards.
  assign dec_n  = accept ? dec : dec_q;
  assign last_n = accept ? last_round(key_len) : last_q;

  // Output decode from the post-edge state/counters so the registered outputs line up with state.
  logic       ready_d, in_ready_d, sel2_d, f_sel_d, wk_en_d, out_valid_d, done_d;
  logic [1:0] sel1_d, wk_sel_d;
  logic [5:0] rk_d;
  logic [4:0] round_d;
  logic [4:0] rk_idx;

  assign rk_idx = dec_n ? (last_n - i_nxt) : i_nxt;

  always_comb begin
    ready_d     = 1'b0;
    in_ready_d  = 1'b0;
    sel1_d      = SEL1_R7;
    sel2_d      = 1'b0;
    f_sel_d     = 1'b0;
    rk_d        = 6'd0;
    wk_en_d     = 1'b0;
    wk_sel_d    = 2'd0;
    round_d     = 5'd0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_nxt)
      ST_IDLE: ready_d = 1'b1;
      ST_LOAD: begin
        in_ready_d = 1'b1;
        // Whitening on ph1/ph3; decrypt uses WK2/WK3 on the way in.
        wk_en_d    = ph_nxt[0];
        if (ph_nxt[0]) wk_sel_d = {dec_n, ph_nxt[1]};
      end
      ST_ROUND: begin
        sel2_d  = 1'b1;
        f_sel_d = ph_nxt[1];
        round_d = i_nxt;
        rk_d    = {rk_idx, 1'b0} + {5'd0, ph_nxt[1]};
        // The final round skips the word permutation.
        if (i_nxt == last_n)  sel1_d = SEL1_R7;
        else if (ph_nxt[0])   sel1_d = SEL1_R3;
        else                  sel1_d = SEL1_R1;
      end
      ST_OUT: begin
        sel2_d      = 1'b1;
        out_valid_d = 1'b1;
        wk_en_d     = ph_nxt[0];
        if (ph_nxt[0]) wk_sel_d = {~dec_n, ph_nxt[1]};
      end
      ST_DONE: done_d = 1'b1;
      default: ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dec_q     <= 1'b0;
      last_q    <= 5'd0;
      ready     <= 1'b1;
      in_ready  <= 1'b0;
      sel1      <= SEL1_R7;
      sel2      <= 1'b0;
      f_sel     <= 1'b0;
      rk_addr   <= 6'd0;
      wk_en     <= 1'b0;
      wk_sel    <= 2'd0;
      round     <= 5'd0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      dec_q     <= dec_n;
      last_q    <= last_n;
      ready     <= ready_d;
      in_ready  <= in_ready_d;
      sel1      <= sel1_d;
      sel2      <= sel2_d;
      f_sel     <= f_sel_d;
      rk_addr   <= rk_d;
      wk_en     <= wk_en_d;
      wk_sel    <= wk_sel_d;
      round     <= round_d;
      out_valid <= out_valid_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_clefia_round_ctrl.sv
// tb_clefia_round_ctrl: directed blocks; expected event streams queued at start acceptance,
// a negedge monitor pops and compares every LOAD/ROUND/OUT/DONE cycle the DUT presents.
module tb_clefia_round_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] key_len;
  logic       dec;
  logic       abort;
  logic       ready, in_ready, sel2, f_sel, wk_en, out_valid, done;
  logic [1:0] sel1, wk_sel;
  logic [5:0] rk_addr;
  logic [4:0] round;

  clefia_round_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_len   (key_len),
    .dec       (dec),
    .abort     (abort),
    .ready     (ready),
    .in_ready  (in_ready),
    .sel1      (sel1),
    .sel2      (sel2),
    .f_sel     (f_sel),
    .rk_addr   (rk_addr),
    .wk_en     (wk_en),
    .wk_sel    (wk_sel),
    .round     (round),
    .out_valid (out_valid),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_LOAD = 0, K_ROUND = 1, K_OUT = 2, K_DONE = 3;

  typedef struct {
    int         kind;
    logic [5:0] rk;
    logic [4:0] rnd;
    logic [1:0] sel1;
    logic       f_sel;
    logic       fmask;
    logic       wk_en;
    logic [1:0] wk_sel;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int rounds_of(input logic [1:0] kl);
    if (kl == 2'b01) return 22;
    if (kl == 2'b10) return 26;
    return 18;
  endfunction

  // Queue the expected event stream of one block: 4 LOAD, n_round ROUND, n_out OUT, optional DONE.
  task automatic push_block(input logic [1:0] kl, input logic d, input int n_round,
                            input int n_out, input bit with_done, input int acc);
    exp_t e;
    int   r;
    r = rounds_of(kl);
    for (int p = 0; p < 4; p++) begin
      e = '{default: 0};
      e.kind   = K_LOAD;
      e.wk_en  = (p % 2 == 1);
      e.wk_sel = (p == 1) ? (d ? 2'd2 : 2'd0) : (p == 3) ? (d ? 2'd3 : 2'd1) : 2'd0;
      q.push_back(e);
    end
    for (int k = 0; k < n_round; k++) begin
      int i, p, idx;
      i   = k / 4;
      p   = k % 4;
      idx = d ? (r - 1 - i) : i;
      e = '{default: 0};
      e.kind  = K_ROUND;
      e.rk    = 6'(2 * idx + p / 2);
      e.rnd   = 5'(i);
      e.sel1  = (i == r - 1) ? 2'b00 : ((p % 2 == 1) ? 2'b01 : 2'b10);
      e.f_sel = (p / 2 == 1);
      e.fmask = (p % 2 == 0);
      q.push_back(e);
    end
    for (int p = 0; p < n_out; p++) begin
      e = '{default: 0};
      e.kind   = K_OUT;
      e.wk_en  = (p % 2 == 1);
      e.wk_sel = (p == 1) ? (d ? 2'd0 : 2'd2) : (p == 3) ? (d ? 2'd1 : 2'd3) : 2'd0;
      q.push_back(e);
    end
    if (with_done) begin
      e = '{default: 0};
      e.kind = K_DONE;
      // Acceptance cycle counts as cycle 1, so done lands 4+4r+5-1 cycles after it.
      e.cyc  = acc + 4 + 4 * r + 4;
      q.push_back(e);
    end
  endtask

  // Monitor: classify each cycle the DUT presents an event and compare against the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      int   kind;
      exp_t e;
      kind = -1;
      if (in_ready)                      kind = K_LOAD;
      else if (sel2 && !out_valid)       kind = K_ROUND;
      else if (out_valid)                kind = K_OUT;
      else if (done)                     kind = K_DONE;
      if (kind >= 0) begin
        if (q.size() == 0) begin
          chk("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("event_kind", 32'(kind), 32'(e.kind));
          if (kind == e.kind) begin
            case (kind)
              K_LOAD:  chk("load_fields", 32'({wk_en, wk_sel, sel2, sel1}),
                           32'({e.wk_en, e.wk_sel, 1'b0, 2'b00}));
              K_ROUND: chk("round_fields",
                           32'({rk_addr, round, sel1, f_sel & e.fmask, wk_en}),
                           32'({e.rk, e.rnd, e.sel1, e.f_sel & e.fmask, 1'b0}));
              K_OUT:   chk("out_fields", 32'({wk_en, wk_sel, sel1, sel2}),
                           32'({e.wk_en, e.wk_sel, 2'b00, 1'b1}));
              default: chk("done_cycle", 32'(cyc), 32'(e.cyc));
            endcase
          end
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      if (q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk({name, "_drain_timeout"}, 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_start(input logic [1:0] kl, input logic d, output int acc);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("ready_timeout", 32'(ready), 32'd1);
    start = 1'b1; key_len = kl; dec = d;
    @(posedge clk); #1;
    start = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_round(input int idx, input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (sel2 && !out_valid && round == 5'(idx)) begin ok = 1'b1; break; end
    end
    if (!ok) chk({name, "_timeout"}, 32'(round), 32'(idx));
  endtask

  initial begin
    int acc;
    bit ok;
    rst_n = 1'b0; start = 1'b1; key_len = 2'b00; dec = 1'b0; abort = 1'b0;
    #12;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_outputs", 32'({in_ready, sel1, sel2, f_sel, rk_addr, wk_en, wk_sel, round, out_valid, done}), 32'd0);

    // 128-bit encrypt, start held across reset release: accepted on the first live edge.
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    acc = cyc;
    push_block(2'b00, 1'b0, 72, 4, 1'b1, acc);
    wait_drain("blk128");

    // 256-bit decrypt; key_len/dec wiggled mid-block must not matter.
    do_start(2'b10, 1'b1, acc);
    push_block(2'b10, 1'b1, 104, 4, 1'b1, acc);
    repeat (10) @(negedge clk);
    key_len = 2'b00; dec = 1'b0;
    wait_drain("blk256dec");

    // Reserved key_len code behaves as 128-bit.
    do_start(2'b11, 1'b0, acc);
    push_block(2'b00, 1'b0, 72, 4, 1'b1, acc);
    wait_drain("blk_kl11");

    // 192-bit encrypt.
    do_start(2'b01, 1'b0, acc);
    push_block(2'b01, 1'b0, 88, 4, 1'b1, acc);
    wait_drain("blk192");

    // Asynchronous reset at round 7 ph0: only events up to there are expected.
    do_start(2'b00, 1'b0, acc);
    push_block(2'b00, 1'b0, 29, 0, 1'b0, acc);
    wait_round(7, "rst_round7");
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", 32'(ready), 32'd1);
    chk("async_rst_outputs", 32'({in_ready, sel1, sel2, rk_addr, round, out_valid, done}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_queue_consumed", 32'(q.size()), 32'd0);
    do_start(2'b00, 1'b0, acc);
    push_block(2'b00, 1'b0, 72, 4, 1'b1, acc);
    wait_drain("blk_after_rst");

    // Abort at OUT ph1, with start held high for a while during ROUND.
    do_start(2'b00, 1'b0, acc);
    push_block(2'b00, 1'b0, 72, 2, 1'b0, acc);
    wait_round(3, "busy_start");
    start = 1'b1;
    wait_round(10, "busy_start_end");
    start = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (out_valid && wk_en) begin ok = 1'b1; break; end
    end
    if (!ok) chk("out_ph1_timeout", 32'(out_valid), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_outputs", 32'({out_valid, done, sel2, wk_en}), 32'd0);
    repeat (10) @(negedge clk);
    chk("abort_stays_idle", 32'(ready), 32'd1);
    chk("abort_queue_consumed", 32'(q.size()), 32'd0);

    // Abort and start together in IDLE: abort wins.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_start_ready", 32'(ready), 32'd1);
    chk("abort_start_no_load", 32'(in_ready), 32'd0);

    repeat (5) @(negedge clk);
    chk("final_queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clefia_round_ctrl.md
CLEFIA_ROUND_CTRL -- requirements
Module: clefia_round_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request to process one 128-bit block; accepted only when ready=1.
REQ-004 SHALL have port key_len, input, 2 bits: 00=128-bit (18 rounds), 01=192 (22), 10=256 (26), 11 treated as 00; sampled at start acceptance.
REQ-005 SHALL have port dec, input, 1 bit: 0 encrypt, 1 decrypt; sampled at start acceptance.
REQ-006 SHALL have port abort, input, 1 bit: synchronous return to IDLE without done.
REQ-007 SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-008 SHALL have port in_ready, output, 1 bit: datapath loads an input word this cycle.
REQ-009 SHALL have port sel1, output, 2 bits: feedback tap select for the word register chain (00=R7, 01=R3, 10=R1).
REQ-010 SHALL have port sel2, output, 1 bit: 0 external input word, 1 feedback word.
REQ-011 SHALL have port f_sel, output, 1 bit: 0 selects F0, 1 selects F1.
REQ-012 SHALL have port rk_addr, output, 6 bits: round-key index 0..51.
REQ-013 SHALL have port wk_en, output, 1 bit, and wk_sel, output, 2 bits: whitening-key XOR enable and index WK0..WK3.
REQ-014 SHALL have port round, output, 5 bits: current round index 0..25.
REQ-015 SHALL have ports out_valid and done, output, 1 bit each.

Function
REQ-016 SHALL implement states IDLE, LOAD, ROUND, OUT, DONE.
REQ-017 IDLE->LOAD on start&ready; LOAD lasts 4 cycles (ph 0..3), in_ready=1, sel2=0; wk_en=1 at ph1 (wk_sel=0) and ph3 (wk_sel=1).
REQ-018 LOAD->ROUND after ph3; ROUND lasts 4*r cycles, r per REQ-004, 2-bit phase counter ph, 5-bit round counter i.
REQ-019 In ROUND: sel2=1; ph0 f_sel=0, ph2 f_sel=1; sel1=10 at ph0/ph2, 01 at ph1/ph3; in the final round (i=r-1) sel1=00 for all phases (no word permutation).
REQ-020 rk_addr SHALL be 2*i+(ph>>1) when dec=0 and 2*(r-1-i)+(ph>>1) when dec=1; held at 0 outside ROUND.
REQ-021 ph wraps 3->0 and increments i; ROUND->OUT when i=r-1 and ph=3.
REQ-022 OUT lasts 4 cycles, out_valid=1, sel2=1, sel1=00; wk_en=1 at ph1 (wk_sel=2) and ph3 (wk_sel=3); when dec=1 WK pairs swap (load uses 2,3; out uses 0,1).
REQ-023 OUT->DONE after ph3; DONE lasts 1 cycle with done=1, then IDLE.
REQ-024 start->done latency SHALL be 4+4r+5 cycles counted from acceptance edge: 81 (128), 97 (192), 113 (256).
REQ-025 start while not ready SHALL be ignored; key_len/dec changes mid-block SHALL have no effect.
REQ-026 abort SHALL take priority over all transitions; next cycle IDLE, counters cleared, done not asserted; abort and start together in IDLE: abort wins.
REQ-027 Outputs SHALL be registered (Moore); in IDLE all enables 0, sel1=00, sel2=0.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, ph=0, i=0, ready=1, all other outputs 0, regardless of state.
REQ-029 First start after rst_n deassertion SHALL be accepted on the first rising edge with rst_n=1.

Structure
REQ-030 Package clefia_pkg SHALL hold state encoding, round-count constants (18/22/26), sel1 tap codes and key_len codes.
REQ-031 One sub-module clefia_round_cnt SHALL hold ph/i counters with clear, enable and terminal-count output.

Verification
REQ-032 key_len=00, dec=0, start one cycle -> in_ready 4 cycles, rk_addr 0,0,1,1,...,35,35, out_valid 4 cycles, done at cycle 81.
REQ-033 key_len=10, dec=1 -> rk_addr begins 50,50,51,51 and ends 0,0,1,1; done at cycle 113; wk_sel 2,3 in LOAD, 0,1 in OUT.
REQ-034 key_len=11 -> identical sequence to key_len=00 (18 rounds, done at 81).
REQ-035 rst_n pulsed low at ROUND i=7 -> ready=1 asynchronously, no done; next start produces full 81-cycle block.
REQ-036 abort at OUT ph1 -> IDLE next cycle, out_valid drops, no done; start asserted during busy -> ignored, no second block.
